// File: rtl/heartbeat_pattern_gen.sv
// rtl/heartbeat_pattern_gen.sv - "lub-dub" heartbeat blink pattern generator
//
// Purpose: prescaled 5-state pattern FSM (IDLE/LUB/GAP/DUB/REST) producing a
// registered heartbeat level for the pad driver, with a completed-beat counter.
// Optional macro: HB_EN_SYNC_EN - when defined, en passes through a 2-flop
// synchronizer before use; otherwise en must already be synchronous to clk.
//
// Ports:
//   clk        in   cell clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   run request
//   signal     out  heartbeat level (high in LUB and DUB), registered
//   busy       out  high whenever the FSM is not IDLE, registered
//   beat_count out  completed beats, wraps 255->0
module heartbeat_pattern_gen #(
  parameter int DIV_W      = 8,
  parameter int DIV        = 4,
  parameter int LUB_TICKS  = 2,
  parameter int GAP_TICKS  = 1,
  parameter int DUB_TICKS  = 2,
  parameter int REST_TICKS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       signal,
  output logic       busy,
  output logic [7:0] beat_count
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LUB  = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_DUB  = 3'd3;
  localparam logic [2:0] ST_REST = 3'd4;

  localparam int MAX_A   = (LUB_TICKS > GAP_TICKS) ? LUB_TICKS : GAP_TICKS;
  localparam int MAX_B   = (DUB_TICKS > REST_TICKS) ? DUB_TICKS : REST_TICKS;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int PH_W    = $clog2(MAX_LEN + 1);

  localparam logic [DIV_W-1:0] DIV_M1  = DIV_W'(DIV - 1);
  localparam logic [PH_W-1:0]  LUB_M1  = PH_W'(LUB_TICKS - 1);
  localparam logic [PH_W-1:0]  GAP_M1  = PH_W'(GAP_TICKS - 1);
  localparam logic [PH_W-1:0]  DUB_M1  = PH_W'(DUB_TICKS - 1);
  localparam logic [PH_W-1:0]  REST_M1 = PH_W'(REST_TICKS - 1);

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic             signal_q, signal_d;
  logic             busy_q, busy_d;
  logic [7:0]       beat_q, beat_d;
  logic             en_s;
  logic             tick;
  logic [PH_W-1:0]  len_m1;

`ifdef HB_EN_SYNC_EN
  // Two-stage synchronizer for the pad-sourced enable.
  logic en_s1_q, en_s1_d;
  logic en_s2_q, en_s2_d;

  always_comb begin
    en_s1_d = en;
    en_s2_d = en_s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_s1_q <= 1'b0;
      en_s2_q <= 1'b0;
    end else begin
      en_s1_q <= en_s1_d;
      en_s2_q <= en_s2_d;
    end
  end

  assign en_s = en_s2_q;
`else
  assign en_s = en;
`endif

  assign tick = (presc_q == DIV_M1);

  // Last phase index of the current state; IDLE never consults it.
  always_comb begin
    len_m1 = '0;
    case (state_q)
      ST_LUB:  len_m1 = LUB_M1;
      ST_GAP:  len_m1 = GAP_M1;
      ST_DUB:  len_m1 = DUB_M1;
      ST_REST: len_m1 = REST_M1;
      default: len_m1 = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    phase_d = phase_q;
    beat_d  = beat_q;
    if (state_q == ST_IDLE) begin
      presc_d = '0;
      phase_d = '0;
      if (en_s) state_d = ST_LUB;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        if (phase_q == len_m1) begin
          phase_d = '0;
          case (state_q)
            ST_LUB:  state_d = ST_GAP;
            ST_GAP:  state_d = ST_DUB;
            ST_DUB:  state_d = ST_REST;
            default: begin
              // Leaving REST completes a beat whether we loop or stop.
              beat_d  = beat_q + 8'd1;
              state_d = en_s ? ST_LUB : ST_IDLE;
            end
          endcase
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
    end
    // Outputs are decoded from the next state so they move with the state flop.
    signal_d = (state_d == ST_LUB) || (state_d == ST_DUB);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      presc_q  <= '0;
      phase_q  <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      beat_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      phase_q  <= phase_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      beat_q   <= beat_d;
    end
  end

  assign signal     = signal_q;
  assign busy       = busy_q;
  assign beat_count = beat_q;

endmodule

// File: tb/tb_heartbeat_pattern_gen.sv
// tb/tb_heartbeat_pattern_gen.sv - self-checking bench for heartbeat_pattern_gen
module tb_heartbeat_pattern_gen;

  localparam int LUB = 2, GAP = 1, DUB = 2, REST = 3;
`ifdef HB_EN_SYNC_EN
  localparam int EN_LAT = 3;
`else
  localparam int EN_LAT = 1;
`endif

  logic clk;
  logic rst0, en0, rst1, en1;
  logic sig0, busy0, sig1, busy1;
  logic [7:0] cnt0, cnt1;

  int compared = 0;
  int mismatched = 0;
  bit cmp_en = 0;

  heartbeat_pattern_gen #(.DIV(4)) dut0 (
    .clk(clk), .rst(rst0), .en(en0),
    .signal(sig0), .busy(busy0), .beat_count(cnt0)
  );

  heartbeat_pattern_gen #(.DIV(1)) dut1 (
    .clk(clk), .rst(rst1), .en(en1),
    .signal(sig1), .busy(busy1), .beat_count(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Beat-position model: a running flag plus clock offset within the beat.
  typedef struct {
    bit run;
    int pos;
    int cnt;
    bit s1;
    bit s2;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t step(mdl_t m, bit r, bit e, int div);
    mdl_t n;
    bit es;
    int period;
    n = m;
`ifdef HB_EN_SYNC_EN
    es = m.s2;
`else
    es = e;
`endif
    if (r) begin
      n.run = 0; n.pos = 0; n.cnt = 0; n.s1 = 0; n.s2 = 0;
      return n;
    end
    n.s1 = e;
    n.s2 = m.s1;
    period = (LUB + GAP + DUB + REST) * div;
    if (!m.run) begin
      if (es) begin
        n.run = 1;
        n.pos = 0;
      end
    end else begin
      n.pos = m.pos + 1;
      if (n.pos == period) begin
        n.cnt = (m.cnt + 1) % 256;
        n.pos = 0;
        n.run = es;
      end
    end
    return n;
  endfunction

  function automatic bit msig(mdl_t m, int div);
    return m.run && ((m.pos < LUB * div) ||
                     (m.pos >= (LUB + GAP) * div && m.pos < (LUB + GAP + DUB) * div));
  endfunction

  always @(posedge clk) begin
    m0 = step(m0, rst0, en0, 4);
    m1 = step(m1, rst1, en1, 1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("sig0_model", 32'(sig0), 32'(msig(m0, 4)));
      chk("busy0_model", 32'(busy0), 32'(m0.run));
      chk("cnt0_model", 32'(cnt0), 32'(m0.cnt));
      chk("sig1_model", 32'(sig1), 32'(msig(m1, 1)));
      chk("busy1_model", 32'(busy1), 32'(m1.run));
      chk("cnt1_model", 32'(cnt1), 32'(m1.cnt));
    end
  end

  // Leaves the caller on the first negedge where busy0 is high (k = 0).
  task automatic wait_entry0(input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy0 === 1'b1) begin
        found = 1;
        break;
      end
    end
    chk(name, 32'(found), 32'd1);
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
  endtask

  int sig_k[9] = '{0, 7, 8, 11, 12, 19, 20, 31, 32};
  int sig_v[9] = '{1, 1, 0, 0, 1, 1, 0, 0, 1};

  initial begin
    rst0 = 1'b1; en0 = 1'b1;
    rst1 = 1'b1; en1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;

    // Reset held with en=1: everything stays cleared.
    for (int i = 0; i < 3; i++) begin
      chk("rst_signal", 32'(sig0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_count", 32'(cnt0), 32'd0);
      if (i < 2) @(negedge clk);
    end

    // Continuous run: 8 high / 4 low / 8 high / 12 low.
    rst0 = 1'b0;
    wait_entry0("entry_run");
    for (int k = 0; k <= 64; k++) begin
      for (int j = 0; j < 9; j++)
        if (sig_k[j] == k) chk($sformatf("run_sig_k%0d", k), 32'(sig0), 32'(sig_v[j]));
      if (k == 31) chk("run_cnt_k31", 32'(cnt0), 32'd0);
      if (k == 32) chk("run_cnt_k32", 32'(cnt0), 32'd1);
      if (k == 64) chk("run_cnt_k64", 32'(cnt0), 32'd2);
      if (k < 64) @(negedge clk);
    end

    // Drop en during the first LUB: beat completes then idles.
    reset0();
    wait_entry0("entry_drop");
    for (int k = 0; k <= 72; k++) begin
      if (k == 2) en0 = 1'b0;
      if (k == 31) chk("drop_busy_k31", 32'(busy0), 32'd1);
      if (k == 32) begin
        chk("drop_busy_k32", 32'(busy0), 32'd0);
        chk("drop_cnt_k32", 32'(cnt0), 32'd1);
      end
      if (k == 72) chk("drop_sig_after", 32'(sig0), 32'd0);
      if (k < 72) @(negedge clk);
    end

    // Drop in GAP, re-raise in REST: straight back into LUB.
    en0 = 1'b1;
    reset0();
    wait_entry0("entry_rearm");
    for (int k = 0; k <= 78; k++) begin
      if (k == 9) en0 = 1'b0;
      if (k == 22) en0 = 1'b1;
      if (k == 32) begin
        chk("rearm_busy_k32", 32'(busy0), 32'd1);
        chk("rearm_sig_k32", 32'(sig0), 32'd1);
        chk("rearm_cnt_k32", 32'(cnt0), 32'd1);
      end
      if (k == 64) chk("rearm_cnt_k64", 32'(cnt0), 32'd2);
      // rst pulse in the DUB of the third beat.
      if (k == 78) rst0 = 1'b1;
      if (k < 78) @(negedge clk);
    end
    @(negedge clk);
    rst0 = 1'b0;
    chk("dubrst_sig", 32'(sig0), 32'd0);
    chk("dubrst_busy", 32'(busy0), 32'd0);
    chk("dubrst_cnt", 32'(cnt0), 32'd0);
    wait_entry0("entry_restart");
    chk("restart_sig", 32'(sig0), 32'd1);

    // Random enable/reset activity, checked against the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(19) == 0) en0 = ~en0;
      rst0 = ($urandom_range(299) == 0);
    end
    rst0 = 1'b0;

    // DIV=1 instance: enable latency and beat counter wrap.
    rst1 = 1'b0;
    repeat (3) @(negedge clk);
    en1 = 1'b1;
    for (int i = 1; i <= EN_LAT; i++) begin
      @(negedge clk);
      chk($sformatf("lat_sig_e%0d", i), 32'(sig1), (i == EN_LAT) ? 32'd1 : 32'd0);
    end
    for (int k = 0; k <= 8 * 256; k++) begin
      if (k == 8) chk("wrap_cnt_1", 32'(cnt1), 32'd1);
      if (k == 8 * 255) chk("wrap_cnt_255", 32'(cnt1), 32'd255);
      if (k == 8 * 256 - 1) chk("wrap_cnt_pre", 32'(cnt1), 32'd255);
      if (k == 8 * 256) chk("wrap_cnt_0", 32'(cnt1), 32'd0);
      if (k < 8 * 256) @(negedge clk);
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
